// File: rtl/uart_tx_pkg.sv
// Shared types and timing helpers for the buffered 8N1 UART transmitter.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Clock cycles per UART symbol (integer truncation).
    function automatic int symbol_edge_time(input longint clock_freq, input longint baud_rate);
        return int'(clock_freq / baud_rate);
    endfunction

    function automatic int cnt_width(input int set);
        return $clog2(set);
    endfunction

    localparam int DEFAULT_SET   = symbol_edge_time(50_000_000, 115200);
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_SET);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head read; pointers wrap modulo DEPTH.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/buffered_uart_transmitter.sv
// 8N1 UART transmitter fed from a byte FIFO; back-to-back frames when data is queued.
module buffered_uart_transmitter
    import uart_tx_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic                          serial_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_busy
);
    localparam int SET   = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W = cnt_width(SET);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SET - 1);

    tx_state_t        state;
    logic [CNT_W-1:0] cyc;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             line;

    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             sym_end;

    assign sym_end       = (cyc == LAST);
    assign data_in_ready = !fifo_full;
    assign push          = data_in_valid && data_in_ready;
    // Pop only from registered state, so the line never sees the input path.
    assign pop           = !fifo_empty && ((state == IDLE) || (state == STOP && sym_end));
    assign serial_out    = line;
    assign tx_busy       = (state != IDLE) || !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (data_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cyc     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            line    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    line <= 1'b1;
                    if (pop) begin
                        shift <= fifo_dout;
                        cyc   <= '0;
                        line  <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (sym_end) begin
                        cyc     <= '0;
                        bit_idx <= '0;
                        line    <= shift[0];
                        state   <= DATA;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                DATA: begin
                    if (sym_end) begin
                        cyc <= '0;
                        if (bit_idx == 3'd7) begin
                            line  <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= {1'b0, shift[7:1]};
                            line    <= shift[1];
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                STOP: begin
                    if (sym_end) begin
                        cyc <= '0;
                        if (pop) begin
                            shift <= fifo_dout;
                            line  <= 1'b0;
                            state <= START;
                        end else begin
                            line  <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                default: begin
                    line  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buffered_uart_transmitter.sv
// Randomized and directed bench: frame-level line model, per-cycle compare, line decoder.
module tb_buffered_uart_transmitter;
    localparam int CF    = 1000;
    localparam int BR    = 100;
    localparam int DEPTH = 8;
    localparam int SET   = CF / BR;
    localparam int FRAME = 10 * SET;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;
    logic [3:0] fifo_count;
    logic       tx_busy;

    int tests = 0;
    int fails = 0;

    buffered_uart_transmitter #(
        .CLOCK_FREQ (CF),
        .BAUD_RATE  (BR),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out),
        .fifo_count    (fifo_count),
        .tx_busy       (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: queue of waiting bytes plus position inside the current 10-symbol frame.
    logic [7:0] mq[$];
    logic [7:0] cur = 8'h00;
    int         pos = 0;
    bit         active = 1'b0;
    bit         model_ok = 1'b0;
    bit         m_acc;

    function automatic bit exp_line();
        int k;
        if (!active) return 1'b1;
        k = pos / SET;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return cur[k-1];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            active   = 1'b0;
            pos      = 0;
            model_ok = 1'b1;
        end else begin
            m_acc = data_in_valid && (mq.size() != DEPTH);
            if (active && pos != FRAME - 1) begin
                pos++;
            end else if (mq.size() > 0) begin
                cur    = mq.pop_front();
                active = 1'b1;
                pos    = 0;
            end else begin
                active = 1'b0;
            end
            if (m_acc) mq.push_back(data_in);
        end
    end

    always @(posedge clk) begin
        #1;
        if (model_ok) begin
            check("serial_out", int'(serial_out), int'(exp_line()));
            check("data_in_ready", int'(data_in_ready), int'(mq.size() != DEPTH));
            check("fifo_count", int'(fifo_count), mq.size());
            check("tx_busy", int'(tx_busy), int'(active || mq.size() != 0));
        end
    end

    // Independent line decoder: mid-symbol sampling from the first low sample.
    int         cyc_n = 0;
    logic [7:0] dq[$];
    int         dt[$];
    bit         d_busy = 1'b0;
    int         d_cnt = 0;
    int         d_start = 0;
    logic [7:0] d_sh = 8'h00;

    always @(posedge clk) cyc_n++;

    always @(negedge clk) begin
        if (reset) begin
            d_busy = 1'b0;
        end else if (!d_busy) begin
            if (serial_out === 1'b0) begin
                d_busy  = 1'b1;
                d_cnt   = 0;
                d_start = cyc_n;
            end
        end else begin
            d_cnt++;
            if (d_cnt % SET == SET / 2) begin
                if (d_cnt / SET >= 1 && d_cnt / SET <= 8) begin
                    d_sh[d_cnt / SET - 1] = serial_out;
                end else if (d_cnt / SET == 9) begin
                    check("stop_bit", int'(serial_out), 1);
                    dq.push_back(d_sh);
                    dt.push_back(d_start);
                    d_busy = 1'b0;
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        int g;
        @(negedge clk);
        data_in       = b;
        data_in_valid = 1'b1;
        g = 0;
        while (!data_in_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) check("push_timeout", 0, 1);
    endtask

    task automatic idle_in();
        @(negedge clk);
        data_in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int g;
        g = 0;
        @(negedge clk);
        while (tx_busy && g < lim) begin
            @(negedge clk);
            g++;
        end
        check("wait_idle", int'(tx_busy), 0);
    endtask

    task automatic wait_dec(input int n, input int lim);
        int g;
        g = 0;
        while (dq.size() < n && g < lim) begin
            @(negedge clk);
            g++;
        end
        check("decoded_count", dq.size(), n);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ln [FRAME];
        logic [9:0] pat;
        logic [7:0] sent[$];
        int         bad;
        int         g;
        logic       busy_last;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_serial_out", int'(serial_out), 1);
        check("rst_ready", int'(data_in_ready), 1);
        check("rst_fifo_count", int'(fifo_count), 0);
        check("rst_tx_busy", int'(tx_busy), 0);
        reset = 1'b0;

        // Idle line for 1000 cycles
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (serial_out !== 1'b1 || data_in_ready !== 1'b1) bad++;
        end
        check("idle_bad_cycles", bad, 0);

        // Single frame 0x55 with exact timing from E1
        push_byte(8'h55);
        idle_in();
        for (int c = 0; c < FRAME; c++) begin
            @(posedge clk);
            #1;
            ln[c] = serial_out;
        end
        busy_last = tx_busy;
        @(posedge clk);
        #1;
        check("busy_at_E1_plus_99", int'(busy_last), 1);
        check("busy_at_E1_plus_100", int'(tx_busy), 0);
        pat = 10'b1010101010;
        for (int k = 0; k < 10; k++) begin
            bad = 0;
            for (int j = 0; j < SET; j++)
                if (ln[k*SET + j] !== pat[k]) bad++;
            check($sformatf("sym%0d_of_0x55", k), bad, 0);
        end

        // Back-to-back frames
        wait_idle(500);
        dq.delete();
        dt.delete();
        push_byte(8'hA3);
        push_byte(8'h0F);
        idle_in();
        wait_dec(2, 400);
        if (dq.size() >= 2) begin
            check("b2b_byte0", int'(dq[0]), 'hA3);
            check("b2b_byte1", int'(dq[1]), 'h0F);
            check("b2b_start_gap", dt[1] - dt[0], FRAME);
        end

        // Fill the FIFO, then a push refused on the pop cycle at full
        wait_idle(500);
        dq.delete();
        for (int i = 0; i < 9; i++) push_byte(8'(i));
        @(negedge clk);
        data_in = 8'h09;
        check("ready_low_when_full", int'(data_in_ready), 0);
        check("count_when_full", int'(fifo_count), 8);
        g = 0;
        while (!data_in_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("count_after_pop_at_full", int'(fifo_count), 7);
        check("ready_after_pop_at_full", int'(data_in_ready), 1);
        idle_in();
        wait_dec(10, 1500);
        if (dq.size() >= 10)
            for (int i = 0; i < 10; i++) check($sformatf("fill_byte%0d", i), int'(dq[i]), i);

        // Reset during DATA bit 3 of 0xFF with three bytes queued
        wait_idle(1500);
        dq.delete();
        push_byte(8'hFF);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        idle_in();
        repeat (42) @(negedge clk);
        check("queued_before_reset", int'(fifo_count), 3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_serial_out", int'(serial_out), 1);
        check("abort_fifo_count", int'(fifo_count), 0);
        check("abort_tx_busy", int'(tx_busy), 0);
        @(negedge clk);
        reset = 1'b0;
        dq.delete();
        bad = 0;
        repeat (400) begin
            @(negedge clk);
            if (serial_out !== 1'b1) bad++;
        end
        check("post_abort_line_low_cycles", bad, 0);
        check("post_abort_frames", dq.size(), 0);

        // Random bytes with random producer gaps
        dq.delete();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_in();
                repeat ($urandom_range(1, 250)) @(negedge clk);
            end
            sent.push_back(8'($urandom_range(0, 255)));
            push_byte(sent[i]);
        end
        idle_in();
        wait_dec(40, 8000);
        if (dq.size() >= 40)
            for (int i = 0; i < 40; i++) check($sformatf("rand_byte%0d", i), int'(dq[i]), int'(sent[i]));
        wait_idle(500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
